chip8_tone_gen: RTL and testbench
=================================

# chip8_tone_gen

Parametrised multi-channel square-wave tone generator for the Chip-8 core, clocked by the 12 kHz audio clock. Each channel has a programmable period, a selectable duty cycle and a target amplitude, with a linear attack/release envelope that removes enable clicks. Channel outputs are mixed with saturation into one unsigned 16-bit sample that drives AUDIO_L/AUDIO_R (AUDIO_S = 0). With legacy settings (CHANNELS=1, period 31, 25 % duty, level 0x2000, instant ramp) it reproduces the existing 375 Hz beeper waveform.

## Interface
Parameters:
- CHANNELS, 2 — number of tone channels, ≥1
- PERIOD_W, 8 — width of per-channel period value
- AMP_W, 14 — width of per-channel envelope/level, ≤16
- RAMP_STEP, 64 — envelope increment/decrement per clk_12k cycle, 1..2^AMP_W-1

Ports:
- clk_12k  in  1  audio clock; sole clock of the block
- reset  in  1  synchronous, active-high
- ch_enable  in  CHANNELS  per-channel gate (bit i = channel i)
- ch_period  in  CHANNELS*PERIOD_W  waveform period minus one, in clk_12k cycles; channel i at bits [i*PERIOD_W +: PERIOD_W]
- ch_duty  in  CHANNELS*2  duty select: 00=25 %, 01=50 %, 10=12.5 %, 11=75 %
- ch_level  in  CHANNELS*AMP_W  target amplitude while enabled
- audio_out  out  16  unsigned mixed sample, registered
- ch_active  out  CHANNELS  registered; bit i = channel i envelope ≠ 0

## Operation
- Per-channel state: phase counter (PERIOD_W), latched period P (PERIOD_W), latched duty D (2), envelope env (AMP_W).
- Running condition: ch_enable[i] | (env ≠ 0).
- Phase: while running, phase increments each cycle; when phase == P it wraps to 0, and P/D reload from ch_period/ch_duty on the same edge. When not running, phase = 0 and P/D load every cycle (a fresh start uses current inputs immediately).
- Mid-cycle changes of ch_period/ch_duty have no effect until the next wrap.
- Square wave: let N = P+1 (PERIOD_W+1 bits). High count H = N>>2 (00), N>>1 (01), N>>3 (10), N−(N>>2) (11). sq = (phase ≥ N−H). H = 0 → sq never high; H = N → sq always high.
- Envelope, every cycle:
  - enabled, env < level: env ← min(env+RAMP_STEP, level)
  - enabled, env > level: env ← max(env−RAMP_STEP, level)
  - disabled: env ← max(env−RAMP_STEP, 0)
  - arithmetic carried one bit wider than AMP_W; no wrap-around
- Mix: sum over channels of (sq ? env : 0), width AMP_W+clog2(CHANNELS)+1; audio_out ← min(sum, 16'hFFFF), zero-extended if narrower.
- ch_active[i] ← (next env ≠ 0).

## Timing
- Reset (sync): phase, P, D, env = 0; audio_out = 16'h0000; ch_active = 0. Reset overrides all other activity, including mid-ramp and mid-period.
- Phase/env/P/D update on edge k; audio_out and ch_active reflect those values on edge k+1 (one cycle of output latency).
- Enable rise at edge k: env = min(RAMP_STEP, level) after edge k; phase counts from 0.
- Enable fall: release continues at RAMP_STEP per cycle and the waveform keeps running until env reaches 0; phase then clears on the following edge.
- Re-enable during release: ramp restarts upward from the current env; phase is not reset.
- Period P = 0: phase stays 0, N = 1; 75 % duty is always high, all other duties always low.
- Saturation: all channels at full level with sq high clamps to 0xFFFF and never wraps.

## Test plan
- Legacy: CHANNELS=1, RAMP_STEP=0x2000, AMP_W=14, period=31, duty=00, level=0x2000, enable held → audio_out 0x2000 for 8 cycles, then 0x0000 for 24 cycles, repeating every 32 cycles.
- Attack/release: RAMP_STEP=64, level=256, duty=11, period=3 → audio_out samples rise 64/128/192/256 while sq is high. Enable drops → env falls by 64 per cycle; ch_active clears one cycle after env reaches 0.
- Period change: change ch_period from 15 to 7 at phase 5 → current cycle completes at 16 cycles, then 8-cycle periods; each duty code gives H = 2/4/1/6 for the 8-cycle period.
- Saturation: CHANNELS=8, AMP_W=14, all levels 0x3FFF, duty=11, instant ramp → audio_out = 0xFFFF while all channels are high.
- Reset mid-operation: assert reset for 1 cycle during attack → next cycle audio_out=0, ch_active=0. With enable held, attack restarts from 0.
- Edge cases: period=0 with duty=11 → constant env output; period=0 with duty=00 → constant 0. Re-enable at env=128 → ramp rises from 128 with no phase discontinuity.

Source files
------------

// File: rtl/chip8_tone_gen.sv
// chip8_tone_gen: multi-channel square-wave tone generator with linear attack/release
// envelopes, mixed with saturation into one unsigned 16-bit sample.
module chip8_tone_gen #(
  parameter int CHANNELS  = 2,
  parameter int PERIOD_W  = 8,
  parameter int AMP_W     = 14,
  parameter int RAMP_STEP = 64
) (
  input  logic                         clk_12k,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          ch_enable,
  input  logic [CHANNELS*PERIOD_W-1:0] ch_period,
  input  logic [CHANNELS*2-1:0]        ch_duty,
  input  logic [CHANNELS*AMP_W-1:0]    ch_level,
  output logic [15:0]                  audio_out,
  output logic [CHANNELS-1:0]          ch_active
);
  localparam int SW = AMP_W + $clog2(CHANNELS) + 1;
  localparam logic [AMP_W:0]   STEP   = (AMP_W+1)'(RAMP_STEP);
  localparam logic [AMP_W-1:0] STEP_A = AMP_W'(RAMP_STEP);
  logic [AMP_W-1:0]  env_v [CHANNELS];
  logic [CHANNELS-1:0] sq_v, nz_v;
  logic [SW-1:0]     sum;
  logic [SW+15:0]    sum_x;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [PERIOD_W-1:0] phase, p, per_in;
    logic [1:0]          d, duty_in;
    logic [AMP_W-1:0]    env, env_nxt, lvl;
    logic [AMP_W:0]      e1, l1, up;
    logic [PERIOD_W:0]   n, h;
    logic                run, wrap, sq;
    assign per_in  = ch_period[i*PERIOD_W +: PERIOD_W];
    assign duty_in = ch_duty[i*2 +: 2];
    assign lvl     = ch_level[i*AMP_W +: AMP_W];
    assign run     = ch_enable[i] | (env != '0);
    assign wrap    = phase == p;
    // Envelope math runs one bit wider so neither ramp direction can wrap.
    always_comb begin
      e1 = {1'b0, env};
      l1 = {1'b0, lvl};
      up = e1 + STEP;
      n  = {1'b0, p} + (PERIOD_W+1)'(1);
      h  = d == 2'b00 ? n >> 2 : d == 2'b01 ? n >> 1 : d == 2'b10 ? n >> 3 : n - (n >> 2);
      sq = {1'b0, phase} >= n - h;
      env_nxt = !ch_enable[i] ? (e1 >= STEP ? env - STEP_A : '0) :
                e1 < l1 ? (up > l1 ? lvl : up[AMP_W-1:0]) :
                e1 > l1 ? (e1 >= l1 + STEP ? env - STEP_A : lvl) : env;
    end
    always_ff @(posedge clk_12k) begin
      if (reset) begin
        phase <= '0;
        p     <= '0;
        d     <= '0;
        env   <= '0;
      end else begin
        env   <= env_nxt;
        phase <= (!run || wrap) ? '0 : phase + PERIOD_W'(1);
        if (!run || wrap) begin
          p <= per_in;
          d <= duty_in;
        end
      end
    end
    assign env_v[i] = env;
    assign sq_v[i]  = sq;
    assign nz_v[i]  = env != '0;
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < CHANNELS; k++) sum = sum + (sq_v[k] ? SW'(env_v[k]) : '0);
    sum_x = {16'b0, sum};
  end
  always_ff @(posedge clk_12k) begin
    if (reset) begin
      audio_out <= '0;
      ch_active <= '0;
    end else begin
      audio_out <= sum_x > (SW+16)'(16'hFFFF) ? 16'hFFFF : sum_x[15:0];
      ch_active <= nz_v;
    end
  end
endmodule

// File: tb/tb_chip8_tone_gen.sv
// tb_chip8_tone_gen: randomized and directed stimulus checked against a cycle-level
// arithmetic model of the tone generator.
module tb_chip8_tone_gen;
  localparam int C = 5, PW = 8, AW = 14, RS = 64;
  logic clk_12k = 1'b0, reset = 1'b1;
  logic [C-1:0]    ch_enable;
  logic [C*PW-1:0] ch_period;
  logic [C*2-1:0]  ch_duty;
  logic [C*AW-1:0] ch_level;
  logic [15:0]     audio_out;
  logic [C-1:0]    ch_active;
  int en[C], per[C], dty[C], lvl[C];
  int m_ph[C], m_p[C], m_d[C], m_env[C];
  int exp_audio = 0;
  logic [C-1:0] exp_active = '0;
  int checks = 0, errors = 0;

  chip8_tone_gen #(.CHANNELS(C), .PERIOD_W(PW), .AMP_W(AW), .RAMP_STEP(RS)) dut (
    .clk_12k(clk_12k), .reset(reset), .ch_enable(ch_enable), .ch_period(ch_period),
    .ch_duty(ch_duty), .ch_level(ch_level), .audio_out(audio_out), .ch_active(ch_active));

  always #5 clk_12k = ~clk_12k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int high_cnt(input int n, input int dd);
    return dd == 0 ? n / 4 : dd == 1 ? n / 2 : dd == 2 ? n / 8 : n - n / 4;
  endfunction

  function automatic bit square(input int c);
    int n = m_p[c] + 1;
    return m_ph[c] >= n - high_cnt(n, m_d[c]);
  endfunction

  task automatic model_edge();
    int s = 0;
    if (reset) begin
      exp_audio = 0;
      exp_active = '0;
      for (int c = 0; c < C; c++) begin
        m_ph[c] = 0; m_p[c] = 0; m_d[c] = 0; m_env[c] = 0;
      end
      return;
    end
    for (int c = 0; c < C; c++) begin
      if (square(c)) s += m_env[c];
      exp_active[c] = m_env[c] != 0;
    end
    exp_audio = s > 65535 ? 65535 : s;
    for (int c = 0; c < C; c++) begin
      bit run = en[c] != 0 || m_env[c] != 0;
      if (!run || m_ph[c] == m_p[c]) begin
        m_ph[c] = 0; m_p[c] = per[c]; m_d[c] = dty[c];
      end else m_ph[c]++;
      if (en[c] == 0) m_env[c] = m_env[c] > RS ? m_env[c] - RS : 0;
      else if (m_env[c] < lvl[c]) m_env[c] = m_env[c] + RS < lvl[c] ? m_env[c] + RS : lvl[c];
      else if (m_env[c] > lvl[c]) m_env[c] = m_env[c] - RS > lvl[c] ? m_env[c] - RS : lvl[c];
    end
  endtask

  task automatic step();
    for (int c = 0; c < C; c++) begin
      ch_enable[c]           = en[c][0];
      ch_period[c*PW +: PW]  = PW'(per[c]);
      ch_duty[c*2 +: 2]      = 2'(dty[c]);
      ch_level[c*AW +: AW]   = AW'(lvl[c]);
    end
    @(posedge clk_12k);
    model_edge();
    #1;
    chk("audio_out", 32'(audio_out), 32'(exp_audio));
    chk("ch_active", 32'(ch_active), 32'(exp_active));
  endtask

  task automatic set_all(input int e, input int p, input int d, input int l);
    for (int c = 0; c < C; c++) begin
      en[c] = e; per[c] = p; dty[c] = d; lvl[c] = l;
    end
  endtask

  initial begin
    set_all(0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) step();
    chk("reset_audio", 32'(audio_out), 32'h0);
    chk("reset_active", 32'(ch_active), 32'h0);
    reset = 1'b0;
    // legacy-style beeper on channel 0
    en[0] = 1; per[0] = 31; dty[0] = 0; lvl[0] = 'h2000;
    repeat (300) step();
    en[0] = 0;
    repeat (140) step();
    chk("legacy_release_active", 32'(ch_active), 32'h0);
    // attack / release with mid-attack reset
    en[1] = 1; per[1] = 3; dty[1] = 3; lvl[1] = 256;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("midreset_audio", 32'(audio_out), 32'h0);
    chk("midreset_active", 32'(ch_active), 32'h0);
    reset = 1'b0;
    repeat (12) step();
    en[1] = 0;
    repeat (8) step();
    // period change 15 -> 7 mid-cycle, then each duty code
    en[2] = 1; per[2] = 15; dty[2] = 1; lvl[2] = 1000;
    repeat (21) step();
    per[2] = 7;
    for (int d = 0; d < 4; d++) begin
      dty[2] = d;
      repeat (24) step();
    end
    // re-enable during release
    en[2] = 0;
    repeat (3) step();
    en[2] = 1;
    repeat (10) step();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < C; c++) begin
        if ($urandom_range(31) == 0) en[c] = en[c] ^ 1;
        if ($urandom_range(15) == 0) per[c] = $urandom_range(3) == 0 ? 0 : $urandom_range(20);
        if ($urandom_range(15) == 0) dty[c] = $urandom_range(3);
        if ($urandom_range(31) == 0) lvl[c] = $urandom_range(3) == 0 ? 16383 : $urandom_range(4000);
      end
      reset = $urandom_range(499) == 0;
      step();
    end
    reset = 1'b0;
    // saturation: every channel always high at full level
    set_all(1, 0, 3, 16383);
    repeat (300) step();
    chk("saturation", 32'(audio_out), 32'hFFFF);
    chk("sat_active", 32'(ch_active), 32'h1F);
    // period 0 with 25 % duty is constantly low
    set_all(1, 0, 0, 16383);
    repeat (3) step();
    chk("p0_duty00", 32'(audio_out), 32'h0);
    set_all(0, 0, 0, 0);
    repeat (300) step();
    chk("final_idle", 32'(ch_active), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
